// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and class-based execute (T3-T6) sequencing,
// with control outputs decoded from the registered state and the instruction register.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  opcode,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_R3,
    CLS_MD,
    CLS_R2,
    CLS_NOP,
    CLS_HALT
  } cls_t;

  function automatic cls_t decode_class(input logic [4:0] op);
    cls_t c;
    if (op <= 5'b01000)                        c = CLS_R3;
    else if (op == 5'b01111 || op == 5'b10000) c = CLS_MD;
    else if (op == 5'b10001 || op == 5'b10010) c = CLS_R2;
    else if (op == 5'b11011)                   c = CLS_HALT;
    else                                       c = CLS_NOP;
    return c;
  endfunction

  state_t     cur_state;
  state_t     nxt_state;
  state_t     end_state;
  cls_t       cls;
  logic [4:0] ir_op;
  logic       ir_unused;

  assign ir_op     = ir[31:27];
  assign ir_unused = ^ir[26:0];
  assign cls       = decode_class(ir_op);
  assign end_state = run ? S_T0 : S_IDLE;

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:  nxt_state = run ? S_T0 : S_IDLE;
      S_T0:    nxt_state = S_T1;
      S_T1:    nxt_state = mem_ready ? S_T2 : S_T1;
      S_T2:    nxt_state = S_T3;
      S_T3: begin
        case (cls)
          CLS_HALT: nxt_state = S_HALT;
          CLS_NOP:  nxt_state = end_state;
          default:  nxt_state = S_T4;
        endcase
      end
      S_T4:    nxt_state = S_T5;
      S_T5:    nxt_state = (cls == CLS_MD) ? S_T6 : end_state;
      S_T6:    nxt_state = end_state;
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Output decode: only registered state and ir feed this, so clear zeroes it at once
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ZHighIn  = 1'b0;
    ZLowIn   = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    opcode   = 5'b00000;
    case (cur_state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls == CLS_R3 || cls == CLS_R2) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (cls == CLS_MD) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        opcode = ir_op;
        ZLowIn = 1'b1;
        if (cls == CLS_R3) begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end else if (cls == CLS_MD) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          ZHighIn = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MD) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (cur_state == S_HALT);
  assign state  = cur_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute sequences per class,
// memory wait states, HALT and asynchronous clear.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, Zhighout, Zlowout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic        IncPC, Read, Gra, Grb, Rin, Rout;
  logic [4:0]  opcode;
  logic        halted;
  logic [3:0]  state;
  logic [18:0] ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
                         T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8;

  localparam logic [18:0] M_PCOUT = 19'h40000, M_ZHIGHOUT = 19'h20000, M_ZLOWOUT = 19'h10000,
                          M_MDROUT = 19'h08000, M_MARIN = 19'h04000, M_PCIN = 19'h02000,
                          M_MDRIN = 19'h01000, M_IRIN = 19'h00800, M_YIN = 19'h00400,
                          M_HIIN = 19'h00200, M_LOIN = 19'h00100, M_ZHIGHIN = 19'h00080,
                          M_ZLOWIN = 19'h00040, M_INCPC = 19'h00020, M_READ = 19'h00010,
                          M_GRA = 19'h00008, M_GRB = 19'h00004, M_RIN = 19'h00002,
                          M_ROUT = 19'h00001;
  localparam logic [18:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
  localparam logic [18:0] F_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [18:0] F_T2 = M_MDROUT | M_IRIN;

  assign ctrl = {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, HIin,
                 LOin, ZHighIn, ZLowIn, IncPC, Read, Gra, Grb, Rin, Rout};

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .halted(halted), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    #3;
    n_tests++;
    if (state !== IDLE || ctrl !== 19'h0 || opcode !== 5'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: state=%0d ctrl=%h op=%b halted=%b, expected 0/0/0/0",
               state, ctrl, opcode, halted);
    end
    run = 1'b1;
    @(posedge clock); #1;
    n_tests++;
    if (state !== IDLE || ctrl !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_hold: state=%0d ctrl=%h, expected state=0 ctrl=0", state, ctrl);
    end
    run   = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      n_tests++;
      if (state !== IDLE || ctrl !== 19'h0) begin
        n_fail++;
        $display("FAIL idle_run0 cyc%0d: state=%0d ctrl=%h, expected state=0 ctrl=0", i, state, ctrl);
      end
    end
  endtask

  task automatic test_not();
    logic [3:0]  es[13] = '{T0, T1, T2, T3, T4, T5, T0, T1, T2, T3, T4, T5, IDLE};
    logic [18:0] ec[13] = '{F_T0, F_T1, F_T2, M_GRB | M_ROUT | M_YIN, M_ZLOWIN,
                            M_ZLOWOUT | M_GRA | M_RIN, F_T0, F_T1, F_T2,
                            M_GRB | M_ROUT | M_YIN, M_ZLOWIN, M_ZLOWOUT | M_GRA | M_RIN, 19'h0};
    logic [4:0]  eo[13] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b10010, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0,
                            5'b10010, 5'b0, 5'b0};
    ir = 32'h921B8000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clock); #1;
      n_tests++;
      if (state !== es[i] || ctrl !== ec[i] || opcode !== eo[i] || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL not_cyc%0d: state=%0d ctrl=%h op=%b, expected state=%0d ctrl=%h op=%b",
                 i, state, ctrl, opcode, es[i], ec[i], eo[i]);
      end
      if (i == 6) run = 1'b0;
    end
  endtask

  task automatic test_add();
    logic [3:0]  es[7] = '{T0, T1, T2, T3, T4, T5, IDLE};
    logic [18:0] ec[7] = '{F_T0, F_T1, F_T2, M_GRB | M_ROUT | M_YIN, M_GRA | M_ROUT | M_ZLOWIN,
                           M_ZLOWOUT | M_GRA | M_RIN, 19'h0};
    int drives;
    ir = 32'h00000000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      run = 1'b0;
      n_tests++;
      if (state !== es[i] || ctrl !== ec[i] || opcode !== 5'b0) begin
        n_fail++;
        $display("FAIL add_cyc%0d: state=%0d ctrl=%h op=%b, expected state=%0d ctrl=%h op=00000",
                 i, state, ctrl, opcode, es[i], ec[i]);
      end
      drives = int'(PCout) + int'(Zhighout) + int'(Zlowout) + int'(MDRout) + int'(Rout);
      n_tests++;
      if (drives > 1) begin
        n_fail++;
        $display("FAIL add_bus_onehot cyc%0d: %0d drivers, expected at most 1", i, drives);
      end
    end
  endtask

  task automatic test_mul();
    logic [3:0]  es[8] = '{T0, T1, T2, T3, T4, T5, T6, IDLE};
    logic [18:0] ec[8] = '{F_T0, F_T1, F_T2, M_GRA | M_ROUT | M_YIN,
                           M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN, M_ZLOWOUT | M_LOIN,
                           M_ZHIGHOUT | M_HIIN, 19'h0};
    logic [4:0]  eo[8] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b01111, 5'b0, 5'b0, 5'b0};
    ir = 32'h78000000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      run = 1'b0;
      n_tests++;
      if (state !== es[i] || ctrl !== ec[i] || opcode !== eo[i]) begin
        n_fail++;
        $display("FAIL mul_cyc%0d: state=%0d ctrl=%h op=%b, expected state=%0d ctrl=%h op=%b",
                 i, state, ctrl, opcode, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [3:0]  es[8] = '{T0, T1, T1, T1, T1, T2, T3, IDLE};
    logic [18:0] ec[8] = '{F_T0, F_T1, F_T1, F_T1, F_T1, F_T2, 19'h0, 19'h0};
    ir = 32'hD0000000; mem_ready = 1'b0; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      run = 1'b0;
      n_tests++;
      if (state !== es[i] || ctrl !== ec[i] || opcode !== 5'b0) begin
        n_fail++;
        $display("FAIL memwait_cyc%0d: state=%0d ctrl=%h op=%b, expected state=%0d ctrl=%h op=00000",
                 i, state, ctrl, opcode, es[i], ec[i]);
      end
      if (i == 4) mem_ready = 1'b1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es[5] = '{T0, T1, T2, T3, IDLE};
    logic [18:0] ec[5] = '{F_T0, F_T1, F_T2, 19'h0, 19'h0};
    ir = 32'hF8000000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      run = 1'b0;
      n_tests++;
      if (state !== es[i] || ctrl !== ec[i] || opcode !== 5'b0) begin
        n_fail++;
        $display("FAIL illegal_cyc%0d: state=%0d ctrl=%h op=%b, expected state=%0d ctrl=%h op=00000",
                 i, state, ctrl, opcode, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [3:0] es[4] = '{T0, T1, T2, T3};
    int bad;
    ir = 32'hD8000000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      n_tests++;
      if (state !== es[i] || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_fetch_cyc%0d: state=%0d halted=%b, expected state=%0d halted=0",
                 i, state, halted, es[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 21; i++) begin
      @(posedge clock); #1;
      if (state !== HALT || halted !== 1'b1 || ctrl !== 19'h0 || opcode !== 5'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_hold: %0d of 21 cycles not in HALT with halted=1, expected 0 (last state=%0d halted=%b)",
               bad, state, halted);
    end
    #2 clear = 1'b1;
    #1;
    n_tests++;
    if (state !== IDLE || halted !== 1'b0 || ctrl !== 19'h0) begin
      n_fail++;
      $display("FAIL halt_clear: state=%0d halted=%b ctrl=%h, expected 0/0/0", state, halted, ctrl);
    end
    run = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_clear_mid();
    ir = 32'h00000000; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
    end
    n_tests++;
    if (state !== T4 || ZLowIn !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre: state=%0d ZLowIn=%b, expected state=5 ZLowIn=1", state, ZLowIn);
    end
    #2 clear = 1'b1;
    #1;
    n_tests++;
    if (state !== IDLE || ctrl !== 19'h0 || opcode !== 5'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_async: state=%0d ctrl=%h op=%b halted=%b, expected all 0",
               state, ctrl, opcode, halted);
    end
    run = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_tests++;
      if (state !== IDLE || ctrl !== 19'h0) begin
        n_fail++;
        $display("FAIL clr_idle cyc%0d: state=%0d ctrl=%h, expected state=0 ctrl=0", i, state, ctrl);
      end
    end
    run = 1'b1;
    @(posedge clock); #1;
    run = 1'b0;
    n_tests++;
    if (state !== T0 || ctrl !== F_T0) begin
      n_fail++;
      $display("FAIL clr_restart: state=%0d ctrl=%h, expected state=1 ctrl=%h", state, ctrl, F_T0);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
    end
    n_tests++;
    if (state !== IDLE) begin
      n_fail++;
      $display("FAIL clr_finish: state=%0d, expected 0", state);
    end
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; ir = 32'h0; mem_ready = 1'b0;
    test_reset();
    test_not();
    test_add();
    test_mul();
    test_mem_wait();
    test_illegal();
    test_halt();
    test_clear_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have these ports; clock and reset first:
- clock  in  1  system clock, all state changes on rising edge
- clear  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = fetch/execute continuously, 0 = stop after current instruction
- ir  in  32  instruction register contents from DataPath; opcode = ir[31:27]
- mem_ready  in  1  memory read complete, valid only while Read=1
- PCout, Zhighout, Zlowout, MDRout  out  1 each  bus-drive selects
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn  out  1 each  register load enables
- IncPC, Read  out  1 each  PC increment request, memory read strobe
- Gra, Grb, Rin, Rout  out  1 each  register-field select and enable to select/encode logic
- opcode  out  5  ALU operation
- halted  out  1  1 while in HALT
- state  out  4  current state code, debug

Function
REQ-002 The module SHALL be a Moore FSM with states IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8; `state` SHALL equal the current code.
REQ-003 Decoded instruction classes SHALL be:
- R3: opcode 00000–01000 (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL)
- MD: 01111 MUL, 10000 DIV
- R2: 10001 NEG, 10010 NOT
- NOP: 11010
- HALT: 11011
- all other opcodes: treated as NOP
REQ-004 IDLE: all outputs 0; go to T0 when run=1.
REQ-005 T0: PCout, MARin, IncPC, ZLowIn = 1; go to T1.
REQ-006 T1: Zlowout, PCin, Read, MDRin = 1.
- Stay in T1 while mem_ready=0.
- Go to T2 on the edge where mem_ready=1.
REQ-007 T2: MDRout, IRin = 1; go to T3.
REQ-008 Execute phase decodes ir[31:27] sampled in T3 and later:
- NOP or illegal: T3 asserts nothing; instruction ends after T3.
- HALT: T3 goes to HALT.
REQ-009 R3 sequence:
- T3: Grb, Rout, Yin
- T4: Gra-field operand drive via Rout with opcode = ir[31:27] and ZLowIn
- T5: Zlowout, Gra, Rin; instruction ends after T5
REQ-010 R2 sequence:
- T3: Grb, Rout, Yin
- T4: opcode = ir[31:27], ZLowIn
- T5: Zlowout, Gra, Rin; instruction ends after T5
REQ-011 MD sequence:
- T3: Gra, Rout, Yin
- T4: Grb, Rout, opcode = ir[31:27], ZHighIn, ZLowIn
- T5: Zlowout, LOin
- T6: Zhighout, HIin; instruction ends after T6
REQ-012 opcode SHALL be 00000 (ADD) in every state other than T4, so the ALU adds during T0's increment.
REQ-013 At instruction end, the next state SHALL be T0 if run=1 and IDLE if run=0; run is sampled on that edge only.
REQ-014 run dropping mid-instruction SHALL NOT abort the instruction.
REQ-015 HALT: all control outputs 0 and halted=1; HALT SHALL be left only via clear.
REQ-016 At most one bus-drive output (PCout, Zhighout, Zlowout, MDRout, Rout) SHALL be 1 in any state.
REQ-017 Outputs SHALL be glitch-free decodes of registered state and ir; no output SHALL depend combinationally on run or mem_ready.

Reset
REQ-018 clear=1 SHALL immediately force state=IDLE, all control outputs 0, opcode=00000 and halted=0, independent of clock.
REQ-019 clear asserted mid-instruction, including T1 with Read=1, SHALL drop Read in the same delta, with no completion of the instruction.
REQ-020 After clear deasserts, the first rising edge with run=1 SHALL enter T0.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- NOT (ir=32'h921B8000, mem_ready=1 in T1): state sequence T0,T1,T2,T3,T4,T5,T0; opcode=10010 only in T4; Gra, Rin, Zlowout in T5.
- ADD (ir=32'h00000000 class, run=1): 6-cycle instruction; T4 asserts ZLowIn with opcode 00000; one-hot bus-drive checked every cycle.
- MUL (opcode 01111): T0–T6 = 7 cycles; ZHighIn and ZLowIn together in T4; LOin in T5; HIin in T6.
- mem_ready held 0 for 3 cycles in T1: Read=1, MDRin=1 for 4 cycles, then T2.
- HALT opcode 11011: reaches HALT after T3, halted=1, stays 20 cycles despite run=1; clear returns to IDLE.
- clear pulsed during T4 of ADD: outputs 0 asynchronously, state=IDLE; with run=0 the FSM stays IDLE until run=1.
